// File: rtl/modulo_unit.sv
// modulo_unit: iterative restoring shift-subtract divider answering the GCD
// controller's modulo_start/modulo_ready request. Produces remainder and
// quotient one bit per cycle, with single-cycle fast paths for b==0 and a<b.
//
// Handshake: modulo_start_i is a level request held by the controller until
// it sees modulo_ready_o. modulo_ready_o is registered and high only in DONE.
// DONE is left on the first edge with modulo_start_i low, so every new
// operation needs start low for at least one edge (no re-trigger).
// abort_i wins over everything except the asynchronous reset.
module modulo_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             modulo_start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] zahl_a_i,
   input  logic [WIDTH-1:0] zahl_b_i,
   output logic             modulo_ready_o,
   output logic [WIDTH-1:0] rest_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic             div_by_zero_o,
   output logic             busy_o,
   output logic [1:0]       dbg_state_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rest_q, rest_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic             dbz_q, dbz_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   // Partial remainder shifted left by one with the next dividend bit, and
   // the trial subtraction; MSB of trial set means the subtraction underflowed.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Shift-subtract datapath for the current iteration
   always_comb begin
      shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, divisor_q};
   end

   // Next-state and next-output computation for the whole block
   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      rest_d     = rest_q;
      quotient_d = quotient_q;
      dbz_d      = dbz_q;
      ready_d    = ready_q;
      busy_d     = busy_q;

      if (abort_i) begin
         // Abort drops the operation; the previous result stays visible.
         state_d = ST_IDLE;
         ready_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (modulo_start_i) begin
                  divisor_d = zahl_b_i;
                  quo_d     = zahl_a_i;
                  rem_d     = '0;
                  cnt_d     = CW'(WIDTH);
                  if (zahl_b_i == '0) begin
                     rest_d     = zahl_a_i;
                     quotient_d = '1;
                     dbz_d      = 1'b1;
                     ready_d    = 1'b1;
                     state_d    = ST_DONE;
                  end else if (zahl_a_i < zahl_b_i) begin
                     rest_d     = zahl_a_i;
                     quotient_d = '0;
                     dbz_d      = 1'b0;
                     ready_d    = 1'b1;
                     state_d    = ST_DONE;
                  end else begin
                     dbz_d   = 1'b0;
                     busy_d  = 1'b1;
                     state_d = ST_CALC;
                  end
               end
            end

            ST_CALC: begin
               if (!trial[WIDTH]) begin
                  rem_d = trial;
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted;
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - 1'b1;
               // Last iteration: publish the freshly computed bits directly.
               if (cnt_q == CW'(1)) begin
                  rest_d     = rem_d[WIDTH-1:0];
                  quotient_d = quo_d;
                  ready_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ST_DONE;
               end
            end

            ST_DONE: begin
               if (!modulo_start_i) begin
                  ready_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end

            default: begin
               ready_d = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         rest_q     <= '0;
         quotient_q <= '0;
         dbz_q      <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         rest_q     <= rest_d;
         quotient_q <= quotient_d;
         dbz_q      <= dbz_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign modulo_ready_o = ready_q;
   assign rest_o         = rest_q;
   assign quotient_o     = quotient_q;
   assign div_by_zero_o  = dbz_q;
   assign busy_o         = busy_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_modulo_unit.sv
// Directed testbench for modulo_unit (WIDTH=8) with hand-computed results.
module tb_modulo_unit;

   localparam int W = 8;

   logic         clk;
   logic         rst_ni;
   logic         modulo_start_i;
   logic         abort_i;
   logic [W-1:0] zahl_a_i;
   logic [W-1:0] zahl_b_i;
   logic         modulo_ready_o;
   logic [W-1:0] rest_o;
   logic [W-1:0] quotient_o;
   logic         div_by_zero_o;
   logic         busy_o;
   logic [1:0]   dbg_state_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   modulo_unit #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst_ni         (rst_ni),
      .modulo_start_i (modulo_start_i),
      .abort_i        (abort_i),
      .zahl_a_i       (zahl_a_i),
      .zahl_b_i       (zahl_b_i),
      .modulo_ready_o (modulo_ready_o),
      .rest_o         (rest_o),
      .quotient_o     (quotient_o),
      .div_by_zero_o  (div_by_zero_o),
      .busy_o         (busy_o),
      .dbg_state_o    (dbg_state_o)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start high and consume the accepting edge
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      zahl_a_i       = a;
      zahl_b_i       = b;
      modulo_start_i = 1'b1;
      step();
   endtask

   // Latency in edges counted from the accepting edge (inclusive); bounded
   task automatic wait_ready(output int lat);
      lat = 1;
      while (!modulo_ready_o && lat < 30) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; modulo_start_i = 1'b0; abort_i = 1'b0;
      zahl_a_i = '0; zahl_b_i = '0;
      #2;
      total_cnt++; if (modulo_ready_o !== 1'b0) $display("FAIL rst_ready got %0b want 0", modulo_ready_o); else pass_cnt++;
      total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy_o); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd0) $display("FAIL rst_rest got %0d want 0", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd0) $display("FAIL rst_quot got %0d want 0", quotient_o); else pass_cnt++;
      total_cnt++; if (div_by_zero_o !== 1'b0) $display("FAIL rst_dbz got %0b want 0", div_by_zero_o); else pass_cnt++;
      total_cnt++; if (dbg_state_o !== 2'd0) $display("FAIL rst_state got %0d want 0", dbg_state_o); else pass_cnt++;
      step();
      #2 rst_ni = 1'b1;
      step();
   endtask

   task automatic test_general();
      int lat;
      start_op(8'd48, 8'd18);
      total_cnt++; if (busy_o !== 1'b1) $display("FAIL gen_busy got %0b want 1", busy_o); else pass_cnt++;
      total_cnt++; if (modulo_ready_o !== 1'b0) $display("FAIL gen_early_ready got %0b want 0", modulo_ready_o); else pass_cnt++;
      // Operands changing during CALC must not disturb the result
      zahl_a_i = 8'd3; zahl_b_i = 8'd0;
      wait_ready(lat);
      total_cnt++; if (lat !== 9) $display("FAIL gen_latency got %0d want 9", lat); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd12) $display("FAIL gen_rest got %0d want 12", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd2) $display("FAIL gen_quot got %0d want 2", quotient_o); else pass_cnt++;
      total_cnt++; if (div_by_zero_o !== 1'b0) $display("FAIL gen_dbz got %0b want 0", div_by_zero_o); else pass_cnt++;
      total_cnt++; if (busy_o !== 1'b0) $display("FAIL gen_busy_done got %0b want 0", busy_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
      total_cnt++; if (modulo_ready_o !== 1'b0) $display("FAIL gen_drop_ready got %0b want 0", modulo_ready_o); else pass_cnt++;
      total_cnt++; if (dbg_state_o !== 2'd0) $display("FAIL gen_idle_state got %0d want 0", dbg_state_o); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd12) $display("FAIL gen_hold_rest got %0d want 12", rest_o); else pass_cnt++;
   endtask

   task automatic test_fast_less();
      int lat;
      start_op(8'd5, 8'd7);
      wait_ready(lat);
      total_cnt++; if (lat !== 1) $display("FAIL less_latency got %0d want 1", lat); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd5) $display("FAIL less_rest got %0d want 5", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd0) $display("FAIL less_quot got %0d want 0", quotient_o); else pass_cnt++;
      total_cnt++; if (div_by_zero_o !== 1'b0) $display("FAIL less_dbz got %0b want 0", div_by_zero_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
   endtask

   task automatic test_div_zero();
      int lat;
      start_op(8'd200, 8'd0);
      wait_ready(lat);
      total_cnt++; if (lat !== 1) $display("FAIL dz_latency got %0d want 1", lat); else pass_cnt++;
      total_cnt++; if (div_by_zero_o !== 1'b1) $display("FAIL dz_flag got %0b want 1", div_by_zero_o); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd200) $display("FAIL dz_rest got %0d want 200", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'hFF) $display("FAIL dz_quot got %0h want ff", quotient_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
      total_cnt++; if (div_by_zero_o !== 1'b1) $display("FAIL dz_hold got %0b want 1", div_by_zero_o); else pass_cnt++;
   endtask

   task automatic test_extremes();
      int lat;
      start_op(8'd255, 8'd1);
      wait_ready(lat);
      total_cnt++; if (lat !== 9) $display("FAIL ext1_latency got %0d want 9", lat); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd0) $display("FAIL ext1_rest got %0d want 0", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd255) $display("FAIL ext1_quot got %0d want 255", quotient_o); else pass_cnt++;
      total_cnt++; if (div_by_zero_o !== 1'b0) $display("FAIL ext1_dbz got %0b want 0", div_by_zero_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
      start_op(8'd255, 8'd255);
      wait_ready(lat);
      total_cnt++; if (lat !== 9) $display("FAIL ext2_latency got %0d want 9", lat); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd0) $display("FAIL ext2_rest got %0d want 0", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd1) $display("FAIL ext2_quot got %0d want 1", quotient_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      int ready_drop;
      int rest_drift;
      start_op(8'd48, 8'd18);
      wait_ready(lat);
      // Hold start for 5 more edges with new operands: no re-trigger allowed
      zahl_a_i = 8'd100; zahl_b_i = 8'd7;
      ready_drop = 0; rest_drift = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (modulo_ready_o !== 1'b1) ready_drop++;
         if (rest_o !== 8'd12) rest_drift++;
      end
      total_cnt++; if (ready_drop !== 0) $display("FAIL hold_ready drops got %0d want 0", ready_drop); else pass_cnt++;
      total_cnt++; if (rest_drift !== 0) $display("FAIL hold_rest changes got %0d want 0", rest_drift); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
      start_op(8'd100, 8'd7);
      wait_ready(lat);
      total_cnt++; if (lat !== 9) $display("FAIL b2b_latency got %0d want 9", lat); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd2) $display("FAIL b2b_rest got %0d want 2", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd14) $display("FAIL b2b_quot got %0d want 14", quotient_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
   endtask

   task automatic test_abort();
      int ready_seen;
      // Abort has priority over start in IDLE
      zahl_a_i = 8'd200; zahl_b_i = 8'd3;
      modulo_start_i = 1'b1; abort_i = 1'b1;
      step();
      total_cnt++; if (dbg_state_o !== 2'd0) $display("FAIL abort_prio_state got %0d want 0", dbg_state_o); else pass_cnt++;
      total_cnt++; if (busy_o !== 1'b0) $display("FAIL abort_prio_busy got %0b want 0", busy_o); else pass_cnt++;
      abort_i = 1'b0;
      step(); // accepting edge -> CALC cycle 1
      total_cnt++; if (busy_o !== 1'b1) $display("FAIL abort_calc_busy got %0b want 1", busy_o); else pass_cnt++;
      step(); step(); step(); // now in CALC cycle 4
      abort_i = 1'b1; modulo_start_i = 1'b0;
      step();
      abort_i = 1'b0;
      total_cnt++; if (dbg_state_o !== 2'd0) $display("FAIL abort_state got %0d want 0", dbg_state_o); else pass_cnt++;
      total_cnt++; if (busy_o !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy_o); else pass_cnt++;
      ready_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (modulo_ready_o !== 1'b0) ready_seen++;
         step();
      end
      total_cnt++; if (ready_seen !== 0) $display("FAIL abort_no_ready got %0d want 0", ready_seen); else pass_cnt++;
      total_cnt++; if (rest_o !== 8'd2) $display("FAIL abort_rest got %0d want 2", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd14) $display("FAIL abort_quot got %0d want 14", quotient_o); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int ready_seen;
      start_op(8'd200, 8'd3);
      step(); step(); step();
      #2 rst_ni = 1'b0;
      #1;
      total_cnt++; if (rest_o !== 8'd0) $display("FAIL rmid_rest got %0d want 0", rest_o); else pass_cnt++;
      total_cnt++; if (quotient_o !== 8'd0) $display("FAIL rmid_quot got %0d want 0", quotient_o); else pass_cnt++;
      total_cnt++; if (busy_o !== 1'b0) $display("FAIL rmid_busy got %0b want 0", busy_o); else pass_cnt++;
      total_cnt++; if (dbg_state_o !== 2'd0) $display("FAIL rmid_state got %0d want 0", dbg_state_o); else pass_cnt++;
      modulo_start_i = 1'b0;
      step();
      #2 rst_ni = 1'b1;
      ready_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (modulo_ready_o !== 1'b0 || busy_o !== 1'b0) ready_seen++;
      end
      total_cnt++; if (ready_seen !== 0) $display("FAIL rmid_no_result got %0d want 0", ready_seen); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_general();
      test_fast_less();
      test_div_zero();
      test_extremes();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
